// File: rtl/hpu_pkg.sv
// Shared definitions for the HPU control/status register slave: register map,
// bit positions, handshake state encoding and small helpers.
package hpu_pkg;

  localparam logic [11:0] OFF_CTRL     = 12'h000;
  localparam logic [11:0] OFF_ITEM_NUM = 12'h004;
  localparam logic [11:0] OFF_ADDR_I   = 12'h008;
  localparam logic [11:0] OFF_ADDR_J   = 12'h00C;
  localparam logic [11:0] OFF_SCRATCH  = 12'h010;
  localparam logic [11:0] OFF_STATUS   = 12'h014;
  localparam logic [11:0] OFF_FIN_CNT  = 12'h018;
  localparam logic [11:0] OFF_ID       = 12'h01C;

  localparam int CTL_MATW   = 0;
  localparam int CTL_RUN    = 1;
  localparam int CTL_LAST   = 2;
  localparam int CTL_IRQ_EN = 3;

  localparam int STS_DONE      = 0;
  localparam int STS_LOAD_DONE = 1;
  localparam int STS_BUSY      = 2;

  localparam logic [15:0] ID_MAGIC    = 16'h4850;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  // INI idle | AW/W one half of a write held | AWW write response | AR1 decode | AR2 data out
  typedef enum logic [2:0] {ST_INI, ST_AW, ST_W, ST_AWW, ST_AR1, ST_AR2} axil_state_e;

  typedef struct packed {
    logic aw_rdy;
    logic w_rdy;
    logic ar_rdy;
    logic b_vld;
    logic r_vld;
  } hs_t;

  function automatic hs_t hs_decode(input axil_state_e s);
    hs_t h;
    h.aw_rdy = (s == ST_INI) || (s == ST_W);
    h.w_rdy  = (s == ST_INI) || (s == ST_AW);
    h.ar_rdy = (s == ST_INI);
    h.b_vld  = (s == ST_AWW);
    h.r_vld  = (s == ST_AR2);
    return h;
  endfunction

  function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      r[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
    return r;
  endfunction

  function automatic logic reg_mapped(input logic [11:0] a);
    return a[11:5] == 7'd0;
  endfunction

endpackage

// File: rtl/hpu_axil_fsm.sv
// AXI-Lite handshake engine: collects AW/W in either order, issues one write
// strobe per transaction, and serves single-beat reads through a decode cycle.
module hpu_axil_fsm
  import hpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] awaddr_i,
  input  logic        awvalid_i,
  output logic        awready_o,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  input  logic        wvalid_i,
  output logic        wready_o,
  output logic [1:0]  bresp_o,
  output logic        bvalid_o,
  input  logic        bready_i,
  input  logic [11:0] araddr_i,
  input  logic        arvalid_i,
  output logic        arready_o,
  output logic [31:0] rdata_o,
  output logic [1:0]  rresp_o,
  output logic        rvalid_o,
  input  logic        rready_i,
  output logic        wr_en_o,
  output logic [11:0] wr_addr_o,
  output logic [31:0] wr_data_o,
  output logic [3:0]  wr_strb_o,
  input  logic        wr_err_i,
  output logic        rd_en_o,
  output logic [11:0] rd_addr_o,
  input  logic [31:0] rd_data_i,
  input  logic        rd_err_i
);

  axil_state_e state_q;
  hs_t         hs_q;
  logic        wr_en_q;
  logic        rd_en_q;
  logic [11:0] wr_addr_q;
  logic [11:0] rd_addr_q;
  logic [31:0] wr_data_q;
  logic [3:0]  wr_strb_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;

  // wr_en is raised on entry to AWW, so the register file commits on the
  // following edge and exactly once however long bready is withheld.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_INI;
      hs_q      <= hs_decode(ST_INI);
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      wr_data_q <= '0;
      wr_strb_q <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      case (state_q)
        ST_INI: begin
          if (awvalid_i && wvalid_i) begin
            state_q   <= ST_AWW;
            hs_q      <= hs_decode(ST_AWW);
            wr_addr_q <= awaddr_i;
            wr_data_q <= wdata_i;
            wr_strb_q <= wstrb_i;
            wr_en_q   <= 1'b1;
          end else if (awvalid_i) begin
            state_q   <= ST_AW;
            hs_q      <= hs_decode(ST_AW);
            wr_addr_q <= awaddr_i;
          end else if (wvalid_i) begin
            state_q   <= ST_W;
            hs_q      <= hs_decode(ST_W);
            wr_data_q <= wdata_i;
            wr_strb_q <= wstrb_i;
          end else if (arvalid_i) begin
            state_q   <= ST_AR1;
            hs_q      <= hs_decode(ST_AR1);
            rd_addr_q <= araddr_i;
            rd_en_q   <= 1'b1;
          end
        end
        ST_AW: begin
          if (wvalid_i) begin
            state_q   <= ST_AWW;
            hs_q      <= hs_decode(ST_AWW);
            wr_data_q <= wdata_i;
            wr_strb_q <= wstrb_i;
            wr_en_q   <= 1'b1;
          end
        end
        ST_W: begin
          if (awvalid_i) begin
            state_q   <= ST_AWW;
            hs_q      <= hs_decode(ST_AWW);
            wr_addr_q <= awaddr_i;
            wr_en_q   <= 1'b1;
          end
        end
        ST_AWW: begin
          if (bready_i) begin
            state_q <= ST_INI;
            hs_q    <= hs_decode(ST_INI);
          end
        end
        ST_AR1: begin
          state_q <= ST_AR2;
          hs_q    <= hs_decode(ST_AR2);
          rdata_q <= rd_data_i;
          rresp_q <= rd_err_i ? RESP_SLVERR : RESP_OKAY;
        end
        ST_AR2: begin
          if (rready_i) begin
            state_q <= ST_INI;
            hs_q    <= hs_decode(ST_INI);
          end
        end
        default: begin
          state_q <= ST_INI;
          hs_q    <= hs_decode(ST_INI);
        end
      endcase
    end
  end

  assign awready_o = hs_q.aw_rdy;
  assign wready_o  = hs_q.w_rdy;
  assign arready_o = hs_q.ar_rdy;
  assign bvalid_o  = hs_q.b_vld;
  assign rvalid_o  = hs_q.r_vld;
  assign bresp_o   = (hs_q.b_vld && wr_err_i) ? RESP_SLVERR : RESP_OKAY;
  assign rdata_o   = rdata_q;
  assign rresp_o   = rresp_q;
  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign wr_strb_o = wr_strb_q;
  assign rd_en_o   = rd_en_q;
  assign rd_addr_o = rd_addr_q;

endmodule

// File: rtl/hpu_ctrl_regs.sv
// HPU control/status register slave: AXI-Lite register file, item-memory load
// counter with automatic matw termination, completion tracking and interrupt.
module hpu_ctrl_regs
  import hpu_pkg::*;
#(
  parameter int          ADDR_IJ_W   = 20,
  parameter int          ITEM_W      = 16,
  parameter int          NUM_CORE    = 1,
  parameter logic [31:0] SCRATCH_RST = 32'h0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [11:0]          s_axi_awaddr,
  input  logic                 s_axi_awvalid,
  output logic                 s_axi_awready,
  input  logic [31:0]          s_axi_wdata,
  input  logic [3:0]           s_axi_wstrb,
  input  logic                 s_axi_wvalid,
  output logic                 s_axi_wready,
  output logic [1:0]           s_axi_bresp,
  output logic                 s_axi_bvalid,
  input  logic                 s_axi_bready,
  input  logic [11:0]          s_axi_araddr,
  input  logic                 s_axi_arvalid,
  output logic                 s_axi_arready,
  output logic [31:0]          s_axi_rdata,
  output logic [1:0]           s_axi_rresp,
  output logic                 s_axi_rvalid,
  input  logic                 s_axi_rready,
  input  logic                 s_fin,
  output logic                 run,
  output logic                 matw,
  output logic                 last,
  output logic [ITEM_W-1:0]    mat_a,
  output logic [ADDR_IJ_W-1:0] addr_i,
  output logic [ADDR_IJ_W-1:0] addr_j,
  output logic                 irq
);

  logic        wr_en, rd_en, wr_err, rd_err;
  logic [11:0] wr_addr, rd_addr;
  logic [31:0] wr_data, rd_data;
  logic [3:0]  wr_strb;

  hpu_axil_fsm u_fsm (
    .clk       (clk),
    .rst       (rst),
    .awaddr_i  (s_axi_awaddr),
    .awvalid_i (s_axi_awvalid),
    .awready_o (s_axi_awready),
    .wdata_i   (s_axi_wdata),
    .wstrb_i   (s_axi_wstrb),
    .wvalid_i  (s_axi_wvalid),
    .wready_o  (s_axi_wready),
    .bresp_o   (s_axi_bresp),
    .bvalid_o  (s_axi_bvalid),
    .bready_i  (s_axi_bready),
    .araddr_i  (s_axi_araddr),
    .arvalid_i (s_axi_arvalid),
    .arready_o (s_axi_arready),
    .rdata_o   (s_axi_rdata),
    .rresp_o   (s_axi_rresp),
    .rvalid_o  (s_axi_rvalid),
    .rready_i  (s_axi_rready),
    .wr_en_o   (wr_en),
    .wr_addr_o (wr_addr),
    .wr_data_o (wr_data),
    .wr_strb_o (wr_strb),
    .wr_err_i  (wr_err),
    .rd_en_o   (rd_en),
    .rd_addr_o (rd_addr),
    .rd_data_i (rd_data),
    .rd_err_i  (rd_err)
  );

  logic                 run_q, run_d, matw_q, matw_d, last_q, last_d, irq_en_q, irq_en_d;
  logic                 done_q, done_d, load_done_q, load_done_d;
  logic [ITEM_W-1:0]    item_num_q, item_num_d, mat_a_q, mat_a_d;
  logic [ADDR_IJ_W-1:0] addr_i_q, addr_i_d, addr_j_q, addr_j_d;
  logic [31:0]          scratch_q, scratch_d;
  logic [15:0]          fin_cnt_q, fin_cnt_d;

  logic [11:0] wsel;
  logic        wr_ctrl, wr_item, wr_ai, wr_aj, wr_scr, wr_status;
  logic [3:0]  ctrl_cur, ctrl_w;
  logic        term, w1c_done, w1c_load;

  always_comb begin
    ctrl_cur             = '0;
    ctrl_cur[CTL_MATW]   = matw_q;
    ctrl_cur[CTL_RUN]    = run_q;
    ctrl_cur[CTL_LAST]   = last_q;
    ctrl_cur[CTL_IRQ_EN] = irq_en_q;
  end

  always_comb begin
    wsel      = wr_addr & 12'hFFC;
    wr_err    = !reg_mapped(wr_addr);
    wr_ctrl   = wr_en && (wsel == OFF_CTRL);
    wr_item   = wr_en && (wsel == OFF_ITEM_NUM);
    wr_ai     = wr_en && (wsel == OFF_ADDR_I);
    wr_aj     = wr_en && (wsel == OFF_ADDR_J);
    wr_scr    = wr_en && (wsel == OFF_SCRATCH);
    wr_status = wr_en && (wsel == OFF_STATUS);
    ctrl_w    = 4'(apply_strb(32'(ctrl_cur), wr_data, wr_strb));

    term     = matw_q && (mat_a_q == item_num_q);
    matw_d   = matw_q && !term;
    run_d    = run_q;
    last_d   = last_q;
    irq_en_d = irq_en_q;
    // A software CTRL write overrides the automatic matw clear in the same cycle.
    if (wr_ctrl) begin
      matw_d   = ctrl_w[CTL_MATW];
      run_d    = ctrl_w[CTL_RUN];
      last_d   = ctrl_w[CTL_LAST];
      irq_en_d = ctrl_w[CTL_IRQ_EN];
    end
    mat_a_d = (matw_d && matw_q && !term) ? mat_a_q + ITEM_W'(1) : '0;

    item_num_d = wr_item ? ITEM_W'(apply_strb(32'(item_num_q), wr_data, wr_strb)) : item_num_q;
    addr_i_d   = wr_ai ? ADDR_IJ_W'(apply_strb(32'(addr_i_q), wr_data, wr_strb)) : addr_i_q;
    addr_j_d   = wr_aj ? ADDR_IJ_W'(apply_strb(32'(addr_j_q), wr_data, wr_strb)) : addr_j_q;
    scratch_d  = wr_scr ? apply_strb(scratch_q, wr_data, wr_strb) : scratch_q;

    w1c_done    = wr_status && wr_strb[0] && wr_data[STS_DONE];
    w1c_load    = wr_status && wr_strb[0] && wr_data[STS_LOAD_DONE];
    done_d      = (s_fin && run_q) || (done_q && !w1c_done);
    load_done_d = term || (load_done_q && !w1c_load);
    fin_cnt_d   = (run_d && !run_q) ? '0 : fin_cnt_q + 16'(s_fin);
  end

  always_comb begin
    rd_data = '0;
    rd_err  = !reg_mapped(rd_addr);
    if (rd_en) begin
      case (rd_addr & 12'hFFC)
        OFF_CTRL:     rd_data = 32'(ctrl_cur);
        OFF_ITEM_NUM: rd_data = 32'(item_num_q);
        OFF_ADDR_I:   rd_data = 32'(addr_i_q);
        OFF_ADDR_J:   rd_data = 32'(addr_j_q);
        OFF_SCRATCH:  rd_data = scratch_q;
        OFF_STATUS: begin
          rd_data[STS_DONE]      = done_q;
          rd_data[STS_LOAD_DONE] = load_done_q;
          rd_data[STS_BUSY]      = run_q && !done_q;
        end
        OFF_FIN_CNT:  rd_data = 32'(fin_cnt_q);
        OFF_ID:       rd_data = {ID_MAGIC, 16'(NUM_CORE)};
        default:      rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q       <= 1'b0;
      matw_q      <= 1'b0;
      last_q      <= 1'b0;
      irq_en_q    <= 1'b0;
      done_q      <= 1'b0;
      load_done_q <= 1'b0;
      item_num_q  <= ITEM_W'(99);
      mat_a_q     <= '0;
      addr_i_q    <= ADDR_IJ_W'(7);
      addr_j_q    <= ADDR_IJ_W'(2);
      scratch_q   <= SCRATCH_RST;
      fin_cnt_q   <= '0;
    end else begin
      run_q       <= run_d;
      matw_q      <= matw_d;
      last_q      <= last_d;
      irq_en_q    <= irq_en_d;
      done_q      <= done_d;
      load_done_q <= load_done_d;
      item_num_q  <= item_num_d;
      mat_a_q     <= mat_a_d;
      addr_i_q    <= addr_i_d;
      addr_j_q    <= addr_j_d;
      scratch_q   <= scratch_d;
      fin_cnt_q   <= fin_cnt_d;
    end
  end

  assign run    = run_q;
  assign matw   = matw_q;
  assign last   = last_q;
  assign mat_a  = mat_a_q;
  assign addr_i = addr_i_q;
  assign addr_j = addr_j_q;
  assign irq    = done_q && irq_en_q;

endmodule

// File: tb/tb_hpu_ctrl_regs.sv
// Directed bench for hpu_ctrl_regs: register-map vector table followed by
// hand-written sequences for split handshakes, matw load, s_fin and reset.
module tb_hpu_ctrl_regs;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] s_axi_awaddr = '0;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b0;
  logic [11:0] s_axi_araddr = '0;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b0;
  logic        s_fin = 1'b0;
  logic        run, matw, last, irq;
  logic [15:0] mat_a;
  logic [19:0] addr_i, addr_j;

  hpu_ctrl_regs dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_fin(s_fin),
    .run(run), .matw(matw), .last(last), .mat_a(mat_a),
    .addr_i(addr_i), .addr_j(addr_j), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_wr;
    logic [11:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: no handshake after 20 cycles, expected one", nm);
  endtask

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int n;
    s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b1;
    n = 0;
    while (!(s_axi_awready && s_axi_wready) && n < 20) begin @(posedge clk); #1; n++; end
    if (n == 20) timeout("write_aw");
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    n = 0;
    while (!s_axi_bvalid && n < 20) begin @(posedge clk); #1; n++; end
    if (n == 20) timeout("write_b");
    resp = s_axi_bresp;
    @(posedge clk); #1;
    s_axi_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    s_axi_araddr = a; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
    n = 0;
    while (!s_axi_arready && n < 20) begin @(posedge clk); #1; n++; end
    if (n == 20) timeout("read_ar");
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    n = 0;
    while (!s_axi_rvalid && n < 20) begin @(posedge clk); #1; n++; end
    if (n == 20) timeout("read_r");
    d = s_axi_rdata;
    resp = s_axi_rresp;
    @(posedge clk); #1;
    s_axi_rready = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(a, d, r);
    check(nm, d, exp);
    check({nm, "_rresp"}, 32'(r), 32'(0));
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [1:0] exp_resp);
    logic [1:0] r;
    axi_write(a, d, 4'hF, r);
    check("bresp", 32'(r), 32'(exp_resp));
  endtask

  task automatic pulse_fin();
    s_fin = 1'b1;
    @(posedge clk); #1;
    s_fin = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500us, expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;

    vecs.push_back('{1'b0, 12'h008, 32'h0,        4'h0,    32'h7,        2'b00});
    vecs.push_back('{1'b0, 12'h00C, 32'h0,        4'h0,    32'h2,        2'b00});
    vecs.push_back('{1'b0, 12'h004, 32'h0,        4'h0,    32'd99,       2'b00});
    vecs.push_back('{1'b0, 12'h01C, 32'h0,        4'h0,    32'h48500001, 2'b00});
    vecs.push_back('{1'b0, 12'h010, 32'h0,        4'h0,    32'h0,        2'b00});
    vecs.push_back('{1'b0, 12'h014, 32'h0,        4'h0,    32'h0,        2'b00});
    vecs.push_back('{1'b0, 12'h018, 32'h0,        4'h0,    32'h0,        2'b00});
    vecs.push_back('{1'b0, 12'h000, 32'h0,        4'h0,    32'h0,        2'b00});
    vecs.push_back('{1'b1, 12'h008, 32'hFFFFFFFF, 4'hF,    32'h0,        2'b00});
    vecs.push_back('{1'b0, 12'h008, 32'h0,        4'h0,    32'h000FFFFF, 2'b00});
    vecs.push_back('{1'b1, 12'h00C, 32'h12345678, 4'b0010, 32'h0,        2'b00});
    vecs.push_back('{1'b0, 12'h00C, 32'h0,        4'h0,    32'h00005602, 2'b00});
    vecs.push_back('{1'b1, 12'h004, 32'hABCD1234, 4'hF,    32'h0,        2'b00});
    vecs.push_back('{1'b0, 12'h004, 32'h0,        4'h0,    32'h00001234, 2'b00});
    vecs.push_back('{1'b1, 12'h004, 32'hFFFF5603, 4'b0001, 32'h0,        2'b00});
    vecs.push_back('{1'b0, 12'h004, 32'h0,        4'h0,    32'h00001203, 2'b00});
    vecs.push_back('{1'b1, 12'h004, 32'h00000003, 4'hF,    32'h0,        2'b00});
    vecs.push_back('{1'b0, 12'h004, 32'h0,        4'h0,    32'h3,        2'b00});
    vecs.push_back('{1'b1, 12'h000, 32'h00000004, 4'b1110, 32'h0,        2'b00});
    vecs.push_back('{1'b0, 12'h000, 32'h0,        4'h0,    32'h0,        2'b00});
    vecs.push_back('{1'b1, 12'h018, 32'hFFFFFFFF, 4'hF,    32'h0,        2'b00});
    vecs.push_back('{1'b0, 12'h018, 32'h0,        4'h0,    32'h0,        2'b00});
    vecs.push_back('{1'b1, 12'h01C, 32'h0,        4'hF,    32'h0,        2'b00});
    vecs.push_back('{1'b0, 12'h01C, 32'h0,        4'h0,    32'h48500001, 2'b00});
    vecs.push_back('{1'b0, 12'h040, 32'h0,        4'h0,    32'h0,        2'b10});
    vecs.push_back('{1'b1, 12'h040, 32'h0,        4'hF,    32'h0,        2'b10});
    vecs.push_back('{1'b0, 12'h7FC, 32'h0,        4'h0,    32'h0,        2'b10});

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_awready", 32'(s_axi_awready), 32'(1));
    check("rst_arready", 32'(s_axi_arready), 32'(1));
    check("rst_bvalid",  32'(s_axi_bvalid),  32'(0));
    check("rst_rvalid",  32'(s_axi_rvalid),  32'(0));
    check("rst_matw",    32'(matw),          32'(0));
    check("rst_mat_a",   32'(mat_a),         32'(0));
    check("rst_addr_i",  32'(addr_i),        32'(7));
    check("rst_addr_j",  32'(addr_j),        32'(2));
    check("rst_irq",     32'(irq),           32'(0));

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].is_wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, r);
        check($sformatf("vec%0d_bresp", i), 32'(r), 32'(vecs[i].exp_resp));
      end else begin
        axi_read(vecs[i].addr, d, r);
        check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_data);
        check($sformatf("vec%0d_rresp", i), 32'(r), 32'(vecs[i].exp_resp));
      end
    end
    check("port_addr_i", 32'(addr_i), 32'h000FFFFF);
    check("port_addr_j", 32'(addr_j), 32'h00005602);

    // AW first, W three cycles later, response held back by bready
    s_axi_awaddr = 12'h010; s_axi_awvalid = 1'b1; s_axi_bready = 1'b0;
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
    check("split_awready_low", 32'(s_axi_awready), 32'(0));
    check("split_wready_high", 32'(s_axi_wready),  32'(1));
    repeat (2) begin @(posedge clk); #1; end
    s_axi_wdata = 32'hDEADBEEF; s_axi_wstrb = 4'b0101; s_axi_wvalid = 1'b1;
    @(posedge clk); #1;
    s_axi_wvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("split_bvalid_hold", 32'(s_axi_bvalid), 32'(1));
      @(posedge clk); #1;
    end
    check("split_bresp", 32'(s_axi_bresp), 32'(0));
    s_axi_bready = 1'b1;
    @(posedge clk); #1;
    s_axi_bready = 1'b0;
    check("split_bvalid_drop", 32'(s_axi_bvalid), 32'(0));
    rd_chk("split_scratch", 12'h010, 32'h00AD00EF);

    // item-memory load with ITEM_NUM=3
    wr(12'h000, 32'h1, 2'b00);
    for (int i = 0; i < 4; i++) begin
      check("load_matw", 32'(matw), 32'(1));
      check("load_mat_a", 32'(mat_a), 32'(i));
      @(posedge clk); #1;
    end
    check("load_matw_end", 32'(matw), 32'(0));
    check("load_mat_a_end", 32'(mat_a), 32'(0));
    rd_chk("load_status", 12'h014, 32'h2);
    rd_chk("load_ctrl", 12'h000, 32'h0);
    wr(12'h014, 32'h2, 2'b00);
    rd_chk("load_done_w1c", 12'h014, 32'h0);

    // run with interrupt enabled, completion pulses
    wr(12'h000, 32'h0A, 2'b00);
    check("run_port", 32'(run), 32'(1));
    rd_chk("run_busy", 12'h014, 32'h4);
    pulse_fin();
    pulse_fin();
    check("fin_irq", 32'(irq), 32'(1));
    rd_chk("fin_status", 12'h014, 32'h1);
    rd_chk("fin_cnt2", 12'h018, 32'h2);

    // W1C of done coincident with a third s_fin
    s_axi_awaddr = 12'h014; s_axi_wdata = 32'h1; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b1;
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    check("w1c_race_bvalid", 32'(s_axi_bvalid), 32'(1));
    s_fin = 1'b1;
    @(posedge clk); #1;
    s_fin = 1'b0; s_axi_bready = 1'b0;
    check("w1c_race_irq", 32'(irq), 32'(1));
    rd_chk("w1c_race_status", 12'h014, 32'h1);
    rd_chk("fin_cnt3", 12'h018, 32'h3);
    wr(12'h014, 32'h1, 2'b00);
    check("w1c_irq_low", 32'(irq), 32'(0));
    rd_chk("w1c_status", 12'h014, 32'h4);

    wr(12'h000, 32'h4, 2'b00);
    check("last_port", 32'(last), 32'(1));
    check("run_off_port", 32'(run), 32'(0));
    pulse_fin();
    rd_chk("fin_ignored", 12'h014, 32'h0);
    wr(12'h000, 32'h2, 2'b00);
    rd_chk("fin_cnt_clear", 12'h018, 32'h0);
    wr(12'h000, 32'h0, 2'b00);

    // unmapped write must not alias onto CTRL
    wr(12'h040, 32'hFFFFFFFF, 2'b10);
    rd_chk("unmapped_ctrl", 12'h000, 32'h0);
    rd_chk("unmapped_scratch", 12'h010, 32'h00AD00EF);

    // reset while a read response is waiting in AR2
    s_axi_araddr = 12'h008; s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    @(posedge clk); #1;
    check("ar2_rvalid", 32'(s_axi_rvalid), 32'(1));
    #2 rst = 1'b1;
    #1;
    check("rst_mid_rvalid", 32'(s_axi_rvalid), 32'(0));
    check("rst_mid_arready", 32'(s_axi_arready), 32'(1));
    check("rst_mid_addr_i", 32'(addr_i), 32'(7));
    check("rst_mid_addr_j", 32'(addr_j), 32'(2));
    @(posedge clk); #1;
    rst = 1'b0;
    rd_chk("post_rst_scratch", 12'h010, 32'h0);
    rd_chk("post_rst_item", 12'h004, 32'd99);
    rd_chk("post_rst_addr_i", 12'h008, 32'h7);
    rd_chk("post_rst_status", 12'h014, 32'h0);
    rd_chk("post_rst_fin_cnt", 12'h018, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
